script_ram_loader: RTL and testbench
====================================

# script_ram_loader

Loads visualization scripts into the 1024×32 script memory from the UART byte stream, so scripts can be replaced without rebuilding the memory image. Sits between the UART receiver and the write port of the script memory. Consumes a framed byte stream, packs bytes into little-endian 32-bit words, and issues one word write per completed word. Verifies a trailing checksum and reports completion and errors.

## Interface
- `ADDR_WIDTH`, default 12: byte-address width of the write port. Word index is `wr_addr[ADDR_WIDTH-1:2]`.
- `MAX_WORDS`, default 1024: largest accepted word count.
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between bytes while a frame is in progress.
- `clk`  in  1  system clock. All logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid. May assert every cycle.
- `rx_byte`  in  8  received byte.
- `wr_en`  out  1  one-cycle write strobe to the script memory.
- `wr_addr`  out  ADDR_WIDTH  byte address of the write. Always word-aligned (`[1:0]` = 0).
- `wr_data`  out  32  word to write.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse when a frame terminates, whether it succeeds or fails.
- `error`  out  1  sticky failure flag. Cleared when the next sync byte is accepted.

## Operation
- Frame format:
  - sync byte 0x5A
  - CNT_LO, then CNT_HI: word count N, 16-bit, little-endian
  - 4·N data bytes. Each word is sent LSB first.
  - CSUM: XOR of all 4·N data bytes
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, CSUM.
- Transitions, on accepted bytes only:
  - IDLE:
    - 0x5A → CNT_LO, and clear `error`.
    - Any other byte is ignored.
  - CNT_LO: latch the low count byte → CNT_HI.
  - CNT_HI: form N.
    - N = 0 or N > MAX_WORDS → IDLE, set `error`, pulse `done`.
    - Otherwise → DATA. Clear the word index, byte lane and running XOR.
  - DATA:
    - Shift the byte into lane (0..3) of the assembly register and XOR it into the running checksum.
    - On lane 3: write the word at address word_index·4, then increment word_index.
    - After word N−1 is written → CSUM.
  - CSUM: compare the byte with the running XOR.
    - Mismatch sets `error`.
    - In both cases → IDLE and pulse `done`.
    - Words already written are not rolled back.
- Timeout:
  - A counter clears on every accepted byte and counts while `busy`.
  - When it reaches TIMEOUT_CYCLES: → IDLE, set `error`, pulse `done`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Addresses start at 0 for every frame. word_index never exceeds MAX_WORDS−1, so the address never wraps.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0; state=IDLE; all counters=0.
- `wr_en`, `wr_addr` and `wr_data` are registered. `wr_en` is high for exactly the one cycle after the cycle where `rx_valid` delivers lane 3.
- `wr_addr` and `wr_data` hold their values until the next write.
- `done` is high in the cycle after the terminating byte is accepted, or after the timeout count is reached.
- `busy` rises the cycle after the sync byte and falls in the same cycle `done` rises.
- Back-to-back `rx_valid` every cycle is fully supported; no byte is dropped. Throughput is one byte per cycle.
- Timeout and byte arrive in the same cycle: the byte wins and the counter clears.
- `rst` asserted mid-frame: every output returns to its reset value immediately (asynchronously). Bytes following the deassertion are parsed from IDLE.
- The write-port latency is decoupled. This block needs no handshake from the memory; every write completes in one cycle.

## Test plan
- **Two-word load.**
  - Stimulus: 5A 02 00 | 11 22 33 44 | AA BB CC DD | CSUM=(XOR of all 8 data bytes).
  - Required: `wr_en` pulses with (0x000, 0x44332211) and (0x004, 0xDDCCBBAA); `done`=1 once; `error`=0.
- **Bad checksum.**
  - Stimulus: same frame with CSUM=0xFF.
  - Required: both writes occur; `done` pulses; `error`=1 and stays 1 until the next 0x5A.
- **Illegal counts.**
  - Stimulus: 5A 00 00, then 5A 01 04 (N=1025).
  - Required: each sets `error` and pulses `done` after CNT_HI; no `wr_en`.
- **Timeout.**
  - Stimulus: with TIMEOUT_CYCLES=16, send 5A 01 00 11, then no input.
  - Required: `busy` drops and `done`/`error` assert 16 cycles after the last byte; no `wr_en`.
- **Full load at maximum rate.**
  - Stimulus: N=1024 with `rx_valid` held high continuously; junk bytes before the sync byte.
  - Required: 1024 writes at addresses 0x000..0xFFC; the last data word lands at 0xFFC; `error`=0; junk is ignored.
- **Reset mid-frame.**
  - Stimulus: assert `rst` during DATA lane 2, then send a clean one-word frame.
  - Required: outputs clear immediately; the new frame writes at address 0x000 correctly.

Source files
------------

// File: rtl/script_ram_loader_if.sv
// Byte-stream input and script-memory write port of the script RAM loader.
// master drives the UART byte stream; slave is the loader itself.
interface script_ram_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_byte,
    input  wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  rx_valid, rx_byte,
    output wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/script_ram_loader.sv
// Parses framed UART bytes (0x5A, count, little-endian words, XOR checksum)
// into one 32-bit script-memory write per completed word.
module script_ram_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  script_ram_loader_if.slave bus
);
  localparam int              WIDX_W   = ADDR_WIDTH - 2;
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_N    = 17'(MAX_WORDS);
  localparam logic [7:0]      SYNC     = 8'h5A;

  typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         nwords_q, nwords_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          xor_q, xor_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [15:0] n_rx;
  logic        count_bad, last_word, busy, tmo_hit;

  assign n_rx      = {bus.rx_byte, cnt_lo_q};
  assign count_bad = (n_rx == 16'd0) || ({1'b0, n_rx} > MAX_N);
  assign last_word = (lane_q == 2'd3) && (16'(widx_q) == nwords_q - 16'd1);
  assign busy      = (state_q != S_IDLE);
  // An arriving byte always beats an expiring timeout.
  assign tmo_hit   = busy && !bus.rx_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_lo_q  <= '0;
      nwords_q  <= '0;
      widx_q    <= '0;
      lane_q    <= '0;
      asm_q     <= '0;
      xor_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_lo_q  <= cnt_lo_d;
      nwords_q  <= nwords_d;
      widx_q    <= widx_d;
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      xor_q     <= xor_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        S_IDLE:   if (bus.rx_byte == SYNC) state_d = S_CNT_LO;
        S_CNT_LO: state_d = S_CNT_HI;
        S_CNT_HI: state_d = count_bad ? S_IDLE : S_DATA;
        S_DATA:   if (last_word) state_d = S_CSUM;
        S_CSUM:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_lo_d  = cnt_lo_q;
    nwords_d  = nwords_q;
    widx_d    = widx_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    xor_d     = xor_q;
    tmo_d     = busy ? tmo_q + TMO_W'(1) : '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;
    if (tmo_hit) begin
      tmo_d   = '0;
      error_d = 1'b1;
      done_d  = 1'b1;
    end else if (bus.rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: if (bus.rx_byte == SYNC) error_d = 1'b0;
        S_CNT_LO: cnt_lo_d = bus.rx_byte;
        S_CNT_HI: begin
          nwords_d = n_rx;
          if (count_bad) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            widx_d = '0;
            lane_d = '0;
            xor_d  = '0;
          end
        end
        S_DATA: begin
          lane_d = lane_q + 2'd1;
          xor_d  = xor_q ^ bus.rx_byte;
          unique case (lane_q)
            2'd0: asm_d[7:0]   = bus.rx_byte;
            2'd1: asm_d[15:8]  = bus.rx_byte;
            2'd2: asm_d[23:16] = bus.rx_byte;
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = {widx_q, 2'b00};
              wr_data_d = {bus.rx_byte, asm_q};
              // Hold the index on the final word so it never exceeds N-1.
              if (!last_word) widx_d = widx_q + WIDX_W'(1);
            end
          endcase
        end
        S_CSUM: begin
          done_d = 1'b1;
          if (bus.rx_byte != xor_q) error_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
endmodule

// File: tb/tb_script_ram_loader.sv
// Bench for script_ram_loader: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_script_ram_loader;
  localparam int AW   = 12;
  localparam int MAXW = 1024;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  script_ram_loader_if #(.ADDR_WIDTH(AW)) bus();

  script_ram_loader #(
    .ADDR_WIDTH    (AW),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame and the data bytes seen.
  bit          m_in;
  int          m_pos, m_n, m_idle, m_k;
  logic [7:0]  m_lo, m_x;
  logic [7:0]  m_data[$];
  logic        m_wr_en, m_done, m_err;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in = 0; m_pos = 0; m_n = 0; m_idle = 0; m_lo = 0;
      m_data.delete();
      m_wr_en = 0; m_done = 0; m_err = 0; m_addr = '0; m_wdata = '0;
    end else begin
      m_wr_en = 0;
      m_done  = 0;
      if (!bus.rx_valid) begin
        if (m_in) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_in = 0; m_done = 1; m_err = 1;
          end
        end
      end else begin
        m_idle = 0;
        if (!m_in) begin
          if (bus.rx_byte == 8'h5A) begin
            m_in = 1; m_pos = 1; m_err = 0; m_data.delete();
          end
        end else if (m_pos == 1) begin
          m_lo = bus.rx_byte; m_pos = 2;
        end else if (m_pos == 2) begin
          m_n = int'({bus.rx_byte, m_lo});
          if (m_n == 0 || m_n > MAXW) begin
            m_in = 0; m_err = 1; m_done = 1;
          end else m_pos = 3;
        end else if (m_data.size() < 4 * m_n) begin
          m_data.push_back(bus.rx_byte);
          if (m_data.size() % 4 == 0) begin
            m_k = m_data.size() / 4 - 1;
            m_wr_en = 1;
            m_addr  = AW'(4 * m_k);
            m_wdata = {m_data[4*m_k+3], m_data[4*m_k+2], m_data[4*m_k+1], m_data[4*m_k]};
          end
        end else begin
          m_x = 8'h00;
          foreach (m_data[i]) m_x ^= m_data[i];
          if (m_x != bus.rx_byte) m_err = 1;
          m_done = 1; m_in = 0;
        end
      end
    end
  end

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            done_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("wr_en",   32'(bus.wr_en),   32'(m_wr_en));
      chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
      chk("wr_data", bus.wr_data,      m_wdata);
      chk("busy",    32'(bus.busy),    32'(m_in));
      chk("done",    32'(bus.done),    32'(m_done));
      chk("error",   32'(bus.error),   32'(m_err));
      if (bus.wr_en) begin
        log_addr.push_back(bus.wr_addr);
        log_data.push_back(bus.wr_data);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'($urandom);
    end
  endtask

  task automatic rgap();
    int n;
    n = $urandom_range(0, 3);
    if (n > 0) gap(n);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, bus.wr_data,      32'd0);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_error"},   32'(bus.error),   32'd0);
  endtask

  int         at, bad;
  logic [7:0] fl[4096];
  logic [7:0] x;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two-word load; checksum of the eight data bytes is 0x44.
    clear_log();
    send(8'h5A); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h44);
    gap(3);
    chk("two_nwr", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("two_addr0", 32'(log_addr[0]), 32'h000);
      chk("two_data0", log_data[0], 32'h44332211);
      chk("two_addr1", 32'(log_addr[1]), 32'h004);
      chk("two_data1", log_data[1], 32'hDDCCBBAA);
    end
    chk("two_done", 32'(done_cnt), 32'd1);
    chk("two_error", 32'(bus.error), 32'd0);

    // Bad checksum.
    clear_log();
    send(8'h5A); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'hFF);
    gap(3);
    chk("bad_nwr", 32'(log_addr.size()), 32'd2);
    chk("bad_done", 32'(done_cnt), 32'd1);
    chk("bad_error", 32'(bus.error), 32'd1);
    gap(10);
    chk("bad_error_sticky", 32'(bus.error), 32'd1);

    // Illegal counts: N=0, then N=1025.
    clear_log();
    send(8'h5A);
    gap(1);
    chk("sync_clears_error", 32'(bus.error), 32'd0);
    send(8'h00); send(8'h00);
    gap(2);
    chk("n0_error", 32'(bus.error), 32'd1);
    chk("n0_done", 32'(done_cnt), 32'd1);
    chk("n0_busy", 32'(bus.busy), 32'd0);
    send(8'h5A); send(8'h01); send(8'h04);
    gap(2);
    chk("n1025_error", 32'(bus.error), 32'd1);
    chk("n1025_done", 32'(done_cnt), 32'd2);
    chk("illegal_nwr", 32'(log_addr.size()), 32'd0);

    // Timeout: last byte driven at negedge 0 is accepted at the following edge;
    // done appears 16 edges later, i.e. first seen at negedge 17.
    clear_log();
    send(8'h5A); send(8'h01); send(8'h00); send(8'h11);
    at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (bus.done && at == 0) at = i;
    end
    chk("tmo_latency", 32'(at), 32'd17);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_error", 32'(bus.error), 32'd1);
    chk("tmo_nwr", 32'(log_addr.size()), 32'd0);

    // Full 1024-word load at one byte per cycle, junk before sync.
    clear_log();
    for (int i = 0; i < 6; i++) begin
      x = 8'($urandom);
      if (x == 8'h5A) x = 8'h00;
      send(x);
    end
    send(8'h5A); send(8'h00); send(8'h04);
    x = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      fl[i] = 8'($urandom);
      x ^= fl[i];
      send(fl[i]);
    end
    send(x);
    gap(3);
    chk("full_nwr", 32'(log_addr.size()), 32'd1024);
    bad = 0;
    foreach (log_addr[i]) if (log_addr[i] != AW'(4 * i)) bad++;
    chk("full_addr_seq", 32'(bad), 32'd0);
    if (log_addr.size() == 1024) begin
      chk("full_last_addr", 32'(log_addr[1023]), 32'hFFC);
      chk("full_last_data", log_data[1023], {fl[4095], fl[4094], fl[4093], fl[4092]});
    end
    chk("full_error", 32'(bus.error), 32'd0);
    chk("full_done", 32'(done_cnt), 32'd1);

    // Reset asserted while the next byte would be lane 2.
    send(8'h5A); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send(8'h5A); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h04);
    gap(3);
    chk("postrst_nwr", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("postrst_addr", 32'(log_addr[0]), 32'h000);
      chk("postrst_data", log_data[0], 32'h04030201);
    end
    chk("postrst_error", 32'(bus.error), 32'd0);
    chk("postrst_done", 32'(done_cnt), 32'd1);

    // Randomized frames: good, bad count, bad checksum, mid-frame timeout.
    for (int f = 0; f < 25; f++) begin
      int mode, n, nj;
      logic [7:0] cs, b;
      mode = $urandom_range(0, 9);
      nj   = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom);
        if (b == 8'h5A) b = 8'h00;
        send(b);
      end
      send(8'h5A);
      if (mode == 0) n = 0;
      else if (mode == 1) n = 1025 + $urandom_range(0, 100);
      else n = $urandom_range(1, 6);
      rgap(); send(8'(n));
      rgap(); send(8'(n >> 8));
      if (mode > 1) begin
        cs = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          rgap();
          if (mode == 2 && j == 2) begin
            gap(TMO + 2);
            break;
          end
          b = 8'($urandom);
          cs ^= b;
          send(b);
        end
        if (mode != 2) begin
          rgap();
          send(mode == 3 ? ~cs : cs);
        end
      end
      gap(3);
    end

    gap(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
